button_bounce_gen: RTL and testbench
====================================

# button_bounce_gen

Synthesizable mechanical-switch emulator: accepts clean level-change commands and drives a single-bit `noisy` output that bounces a bounded, pseudo-random number of times before settling at the commanded level. It is the stimulus end of the button debouncer path. It drives the debouncer's `noisy` input on-chip for hardware-in-the-loop checks of debounce and edge-detect logic, and replaces hand-written toggle loops in benches.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `PAIRS_W`, 2: width of the random bounce-pair count; 0..2^PAIRS_W-1 pairs.
- `SEG_W`, 4: width of the random segment-length offset.
- `MIN_SEG`, 1: minimum segment length in cycles; must be ≥1.
- `FIXED_PAIRS`, 2: bounce-pair count used when `rand_en`=0.
- `SETTLE_CYCLES`, 16: stable hold after the last toggle before `done`; must be ≥1.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_level` input 1: target clean level.
- `cmd_ready` output 1: high exactly when the FSM is in IDLE.
- `rand_en` input 1: 1 selects LFSR-derived pair count and segment lengths; 0 selects `FIXED_PAIRS` and `MIN_SEG`. Sampled at accept and at each segment start.
- `noisy` output 1: emulated contact, registered.
- `busy` output 1: high in BOUNCE and SETTLE.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- Reset values: `noisy`=0, `busy`=0, `done`=0, state IDLE, so `cmd_ready`=1; LFSR=`SEED`; all counters 0. Reset acts immediately, including mid-BOUNCE or mid-SETTLE. Any command in flight is discarded.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advances every cycle out of reset.
- Accept means `cmd_valid && cmd_ready` at a rising edge. `cmd_valid` in other states is ignored, and the requester holds it.
- Same-level accept (`cmd_level`==`noisy`):
  - no toggle;
  - state stays IDLE;
  - `done`=1 for the following cycle;
  - `busy` stays 0.
- Different-level accept:
  - `noisy` takes `cmd_level` at the accept edge;
  - P is latched as `lfsr[PAIRS_W-1:0]` when `rand_en`=1, else `FIXED_PAIRS`;
  - if P=0, go to SETTLE, otherwise go to BOUNCE.
- BOUNCE: 2P segments.
  - Each segment length L = `MIN_SEG` + `lfsr[SEG_W+7:8]` when `rand_en`=1, else `MIN_SEG`. L is sampled at segment start.
  - `noisy` toggles at the end of every segment.
  - After the 2P-th toggle, `noisy`==`cmd_level` and the FSM goes to SETTLE.
- SETTLE: hold `noisy` for `SETTLE_CYCLES` cycles, then go to IDLE and assert `done` for one cycle.
- Invariants:
  - total toggles per different-level command = 2P+1, always odd;
  - `noisy` equals the commanded level whenever `done`=1.

## Timing
- Accept at edge 0, fixed mode, segment length L, P pairs:
  - toggles at edges 0, L, 2L, …, 2P·L;
  - `done` rises at edge 2P·L+`SETTLE_CYCLES` and falls one edge later;
  - `cmd_ready` and `done` are high in the same cycle, so back-to-back accept is possible at the edge ending the `done` cycle.
- `busy` rises at edge 0 and falls at the `done` edge.
- `noisy` is launched from a flop with no combinational path from inputs.
- Counter widths:
  - segment counter: clog2(`MIN_SEG`+2^SEG_W);
  - settle counter: clog2(`SETTLE_CYCLES`+1);
  - pair counter: max(`PAIRS_W`, clog2(`FIXED_PAIRS`+1)).
  - No counter wraps inside a command.

## Structure
- Shared package `button_pkg`:
  - state enum IDLE/BOUNCE/SETTLE;
  - LFSR mask constant 16'hB400;
  - LFSR next-state function.
- One sub-module, `lfsr16`: `clk`, `reset_n`, `SEED` parameter, 16-bit state output; free-running.
- Top holds the FSM, the segment, pair and settle counters, and the `noisy` and `done` flops.
- Elaboration-time checks: `SEED`≠0, `MIN_SEG`≥1, `SETTLE_CYCLES`≥1.

## Test plan
- **Reset:** `reset_n`=0 at any time → `noisy`=0, `busy`=0, `done`=0, `cmd_ready`=1 within the same cycle (no clock needed).
- **Fixed bounce:** `rand_en`=0, `FIXED_PAIRS`=2, `MIN_SEG`=4, `SETTLE_CYCLES`=16; accept `cmd_level`=1 at edge 0 → `noisy` toggles at edges 0, 4, 8, 12, 16, ending high. `done` is pulsed at edge 32, `busy` is high over edges 0–31, and `cmd_ready`=0 in between.
- **Same level:** `noisy`=1, accept `cmd_level`=1 → zero toggles, `done` high the next cycle, `busy` never asserts.
- **Back-pressure:** hold `cmd_valid`=1 with `cmd_level`=0 during the first command → not accepted until the `done` cycle. The second command's first toggle falls on the edge ending the `done` cycle.
- **Mid-bounce reset:** pulse `reset_n` low at edge 6 of the fixed-bounce case → `noisy`=0 and IDLE immediately. A new command then reproduces the fixed-bounce waveform exactly.
- **Random soak:** `rand_en`=1, `SEED`=16'hACE1, 1000 alternating commands. For every command:
  - toggle count is odd and ≤7;
  - every segment length is in [1,16];
  - `noisy`==`cmd_level` at `done`.
  
  With `noisy` feeding the debouncer, its debounced output follows each command exactly once.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the button bounce generator.
package button_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBounce,
    StSettle
  } state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LfsrMask = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every cycle out of reset.
module lfsr16
  import button_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  logic [15:0] state_q;

  // LFSR state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical-switch emulator: turns clean level commands into a bouncing,
// eventually settled single-bit contact signal.
module button_bounce_gen
  import button_pkg::*;
#(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned PAIRS_W       = 2,
  parameter int unsigned SEG_W         = 4,
  parameter int unsigned MIN_SEG       = 1,
  parameter int unsigned FIXED_PAIRS   = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  input  logic rand_en,
  output logic noisy,
  output logic busy,
  output logic done
);

  localparam int unsigned SegW  = $clog2(MIN_SEG + 2 ** SEG_W);
  localparam int unsigned SetW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PairW = max_u(PAIRS_W, $clog2(FIXED_PAIRS + 1));

  if (SEED == 16'h0000) begin : g_chk_seed
    $error("button_bounce_gen: SEED must be nonzero");
  end
  if (MIN_SEG < 1) begin : g_chk_min_seg
    $error("button_bounce_gen: MIN_SEG must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("button_bounce_gen: SETTLE_CYCLES must be at least 1");
  end
  if (SEG_W + 8 > 16 || PAIRS_W < 1 || PAIRS_W > 16) begin : g_chk_widths
    $error("button_bounce_gen: PAIRS_W/SEG_W exceed the LFSR width");
  end

  logic [15:0] lfsr;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  // Only a few LFSR bits feed the pair count and segment length.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr;

  state_e             state_q, state_d;
  logic               noisy_q, noisy_d;
  logic               done_q, done_d;
  logic [SegW-1:0]    seg_q, seg_d;
  logic [PairW-1:0]   pair_q, pair_d;
  logic               half_q, half_d;   // first toggle of the current pair already taken
  logic [SetW-1:0]    settle_q, settle_d;

  logic [SegW-1:0]    seg_len;
  logic [PairW-1:0]   pairs_new;

  assign seg_len   = rand_en ? SegW'(MIN_SEG) + SegW'(lfsr[SEG_W+7:8]) : SegW'(MIN_SEG);
  assign pairs_new = rand_en ? PairW'(lfsr[PAIRS_W-1:0]) : PairW'(FIXED_PAIRS);

  // Next-state logic: accept, bounce segment sequencing and settle countdown
  always_comb begin
    state_d  = state_q;
    noisy_d  = noisy_q;
    done_d   = 1'b0;
    seg_d    = seg_q;
    pair_d   = pair_q;
    half_d   = half_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_level == noisy_q) begin
            done_d = 1'b1;
          end else begin
            noisy_d = cmd_level;
            pair_d  = pairs_new;
            half_d  = 1'b0;
            seg_d   = seg_len;
            if (pairs_new == '0) begin
              state_d  = StSettle;
              settle_d = SetW'(SETTLE_CYCLES);
            end else begin
              state_d = StBounce;
            end
          end
        end
      end
      StBounce: begin
        if (seg_q == SegW'(1)) begin
          noisy_d = ~noisy_q;
          if (half_q && pair_q == PairW'(1)) begin
            state_d  = StSettle;
            settle_d = SetW'(SETTLE_CYCLES);
          end else begin
            seg_d = seg_len;
            if (half_q) begin
              half_d = 1'b0;
              pair_d = pair_q - PairW'(1);
            end else begin
              half_d = 1'b1;
            end
          end
        end else begin
          seg_d = seg_q - SegW'(1);
        end
      end
      StSettle: begin
        if (settle_q == SetW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      noisy_q  <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= '0;
      pair_q   <= '0;
      half_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      noisy_q  <= noisy_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
      pair_q   <= pair_d;
      half_q   <= half_d;
      settle_q <= settle_d;
    end
  end

  assign noisy     = noisy_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign cmd_ready = (state_q == StIdle);

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: fixed-mode vector table on one instance,
// randomized soak against a schedule model on a second instance.
module tb_button_bounce_gen;

  localparam int unsigned SettleCycles = 16;
  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-mode instance (MIN_SEG=4)
  logic f_rst_n, f_valid, f_level, f_ready, f_rand, f_noisy, f_busy, f_done;
  // Random-mode instance (defaults)
  logic r_rst_n, r_valid, r_level, r_ready, r_rand, r_noisy, r_busy, r_done;

  button_bounce_gen #(
    .SEED          (Seed),
    .PAIRS_W       (2),
    .SEG_W         (4),
    .MIN_SEG       (4),
    .FIXED_PAIRS   (2),
    .SETTLE_CYCLES (SettleCycles)
  ) dut_fix (
    .clk       (clk),
    .reset_n   (f_rst_n),
    .cmd_valid (f_valid),
    .cmd_level (f_level),
    .cmd_ready (f_ready),
    .rand_en   (f_rand),
    .noisy     (f_noisy),
    .busy      (f_busy),
    .done      (f_done)
  );

  button_bounce_gen #(
    .SEED          (Seed),
    .PAIRS_W       (2),
    .SEG_W         (4),
    .MIN_SEG       (1),
    .FIXED_PAIRS   (2),
    .SETTLE_CYCLES (SettleCycles)
  ) dut_rnd (
    .clk       (clk),
    .reset_n   (r_rst_n),
    .cmd_valid (r_valid),
    .cmd_level (r_level),
    .cmd_ready (r_ready),
    .rand_en   (r_rand),
    .noisy     (r_noisy),
    .busy      (r_busy),
    .done      (r_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d out of allowed range at %0t", name, act, $time);
    end
  endtask

  // Reference LFSR: the free-running sequence defined by the polynomial.
  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) m_lfsr <= Seed;
    else          m_lfsr <= step(m_lfsr);
  end

  // Fixed-bounce vector table: k = cycles after the accept edge.
  typedef struct {
    int   k;
    logic noisy;
    logic busy;
    logic ready;
    logic done;
  } vec_t;

  vec_t tbl[12];
  int   fk;

  task automatic adv_to(input int target);
    while (fk < target) begin
      @(negedge clk);
      fk++;
    end
  endtask

  task automatic check_fix(input string tag, input logic n, input logic b, input logic r,
                           input logic d);
    check1({tag, "_noisy"}, f_noisy, n);
    check1({tag, "_busy"}, f_busy, b);
    check1({tag, "_ready"}, f_ready, r);
    check1({tag, "_done"}, f_done, d);
  endtask

  // Issue a level-1 command from noisy=0 and walk the table.
  task automatic run_fixed_table(input string tag);
    @(negedge clk);
    f_level = 1'b1;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
    fk = 0;
    for (int i = 0; i < 12; i++) begin
      adv_to(tbl[i].k);
      check_fix($sformatf("%s_k%0d", tag, tbl[i].k), tbl[i].noisy, tbl[i].busy,
                tbl[i].ready, tbl[i].done);
    end
  endtask

  // Asynchronous reset away from any clock edge, checked before the next edge.
  task automatic fix_reset_check(input string tag);
    @(posedge clk);
    #2;
    f_rst_n = 1'b0;
    #1;
    check_fix(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    f_rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{7,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{12, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{15, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{31, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{32, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{33, 1'b1, 1'b0, 1'b1, 1'b0};

    f_rst_n = 1'b0; f_valid = 1'b0; f_level = 1'b0; f_rand = 1'b0;
    r_rst_n = 1'b0; r_valid = 1'b0; r_level = 1'b0; r_rand = 1'b1;

    // Reset values with no clock edge seen yet
    #1;
    check_fix("reset0", 1'b0, 1'b0, 1'b1, 1'b0);
    check1("reset0_rnd_noisy", r_noisy, 1'b0);
    check1("reset0_rnd_ready", r_ready, 1'b1);
    @(negedge clk);
    f_rst_n = 1'b1;
    r_rst_n = 1'b1;

    // Fixed bounce
    run_fixed_table("fixed");

    // Same-level command: noisy already 1
    @(negedge clk);
    f_level = 1'b1;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
    check_fix("same_k0", 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_fix("same_k1", 1'b1, 1'b0, 1'b1, 1'b0);

    // Mid-bounce reset at edge 6, then a clean rerun
    fix_reset_check("rst_pre");
    @(negedge clk);
    f_level = 1'b1;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
    fk = 0;
    adv_to(6);
    check_fix("midrst_k6", 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    f_rst_n = 1'b0;
    #1;
    check_fix("midrst_async", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    f_rst_n = 1'b1;
    run_fixed_table("rerun");

    // Back-pressure: second command held from cycle 0 of the first
    fix_reset_check("rst_bp");
    @(negedge clk);
    f_level = 1'b1;
    f_valid = 1'b1;
    @(negedge clk);
    fk = 0;
    f_level = 1'b0;
    adv_to(5);
    check_fix("bp_k5", 1'b0, 1'b1, 1'b0, 1'b0);
    adv_to(16);
    check_fix("bp_k16", 1'b1, 1'b1, 1'b0, 1'b0);
    adv_to(32);
    check_fix("bp_k32", 1'b1, 1'b0, 1'b1, 1'b1);
    adv_to(33);
    f_valid = 1'b0;
    check_fix("bp_k33", 1'b0, 1'b1, 1'b0, 1'b0);
    adv_to(37);
    check_fix("bp_k37", 1'b1, 1'b1, 1'b0, 1'b0);
    adv_to(49);
    check_fix("bp_k49", 1'b0, 1'b1, 1'b0, 1'b0);
    adv_to(64);
    check_fix("bp_k64", 1'b0, 1'b1, 1'b0, 1'b0);
    adv_to(65);
    check_fix("bp_k65", 1'b0, 1'b0, 1'b1, 1'b1);

    // Random soak on the default-parameter instance
    begin
      int          offs[$];
      logic [15:0] w;
      int          p, t, len, done_off, togg, cnt, last_k, seg;
      logic        tgt, s0, prev, same, rnd, expn;
      for (int c = 0; c < 1000; c++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check1("soak_ready_idle", r_ready, 1'b1);
        same = ($urandom_range(0, 9) == 0);
        rnd  = ($urandom_range(0, 3) != 0);
        s0   = r_noisy;
        tgt  = same ? s0 : ~s0;
        offs.delete();
        if (same) begin
          done_off = 0;
        end else begin
          w = m_lfsr;  // value the DUT sees at the accept edge
          p = rnd ? int'(w[1:0]) : 2;
          t = 0;
          for (int s = 0; s < 2 * p; s++) begin
            len = rnd ? 1 + int'(w[11:8]) : 1;
            t += len;
            repeat (len) w = step(w);
            offs.push_back(t);
          end
          done_off = t + SettleCycles;
        end
        r_level = tgt;
        r_rand  = rnd;
        r_valid = 1'b1;
        togg    = 0;
        last_k  = -1;
        prev    = s0;
        for (int k = 0; k <= done_off; k++) begin
          @(negedge clk);
          if (k == 0) r_valid = 1'b0;
          cnt = same ? 0 : 1;
          foreach (offs[j]) if (offs[j] <= k) cnt++;
          expn = s0 ^ cnt[0];
          check1($sformatf("soak%0d_noisy_k%0d", c, k), r_noisy, expn);
          check1($sformatf("soak%0d_done_k%0d", c, k), r_done, (k == done_off));
          check1($sformatf("soak%0d_busy_k%0d", c, k), r_busy, (!same && k < done_off));
          check1($sformatf("soak%0d_ready_k%0d", c, k), r_ready, (same || k >= done_off));
          if (r_noisy !== prev) begin
            togg++;
            if (last_k >= 0) begin
              seg = k - last_k;
              check_int($sformatf("soak%0d_seglen", c), seg, (seg >= 1 && seg <= 16));
            end
            last_k = k;
          end
          prev = r_noisy;
        end
        check1($sformatf("soak%0d_level_at_done", c), r_noisy, tgt);
        if (same) check_int($sformatf("soak%0d_toggles", c), togg, (togg == 0));
        else check_int($sformatf("soak%0d_toggles", c), togg,
                       (togg % 2 == 1) && (togg <= 7) && (togg == 2 * p + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
